pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline CPU. It drives the enable and flush inputs of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use hazards, taken branches, data-memory wait states and the arithmetic-overflow exception carried into the MEM stage. State updates on negedge clk, the same edge on which the pipeline registers capture.

Parameters:
TMO_W, 4, width of the memory wait counter
MEM_TIMEOUT, 15, wait cycles without mem_ready before a bus-error exception (must fit in TMO_W)
STAT_W, 16, width of the saturating stall statistics counter

Ports:
clk  in  1  clock; all state updates on negedge
rst_n  in  1  asynchronous active-low reset
id_rs  in  5  rs field of the instruction in ID
id_rt  in  5  rt field of the instruction in ID
id_uses_rt  in  1  ID instruction reads rt
ex_memread  in  1  EX instruction is a load
ex_rw  in  5  destination register in EX
ex_regwr  in  1  EX instruction writes the register file
branch_taken  in  1  branch resolved taken in EX
mem_access  in  1  MEM instruction is a load or store
mem_ready  in  1  data memory completes the access this cycle
overflow_mem  in  1  overflow flag of the instruction in MEM
pc_en  out  1  PC update enable
ifid_en  out  1  IF/ID capture enable
ifid_flush  out  1  IF/ID loads a bubble
idex_flush  out  1  ID/EX loads a bubble (control signals forced to 0)
exmem_en  out  1  EX/MEM capture enable
exmem_flush  out  1  EX/MEM loads a bubble
memwb_bubble  out  1  MEM/WB captures RegWr=0 and MemtoReg=0
pc_sel_exc  out  1  PC loads the exception vector
exc_cause  out  2  0 none, 1 overflow, 2 memory timeout; held until the next exception
stall_cnt  out  STAT_W  saturating count of cycles with pc_en=0

Behaviour:
- States: RUN, MEMWAIT, EXC (encoding in package). Reset state: RUN, wait_cnt=0, exc_cause=0, stall_cnt=0.
- While rst_n=0: pc_en=ifid_en=exmem_en=0; ifid_flush=idex_flush=exmem_flush=memwb_bubble=1; pc_sel_exc=0.
- Outputs are a combinational decode of state and current inputs. They must be valid before the next negedge.
- Priority, highest first: exception > memory wait > load-use > branch.
- load_use = ex_memread & ex_regwr & (ex_rw!=0) & (ex_rw==id_rs | (id_uses_rt & ex_rw==id_rt)).
- RUN, default: all enables 1, all flushes 0.
- RUN, overflow_mem=1:
  - Next state EXC; exc_cause<=1.
  - This cycle: memwb_bubble=1 and exmem_flush=1, so the faulting instruction and younger instructions are not committed.
  - ifid_flush=1 and idex_flush=1; pc_en=0.
- RUN, mem_access & !mem_ready (no overflow):
  - Next state MEMWAIT; wait_cnt<=1.
  - pc_en=ifid_en=exmem_en=0; memwb_bubble=1.
- RUN, load_use (no higher event): pc_en=ifid_en=0, idex_flush=1 for exactly one cycle. State stays RUN.
- RUN, branch_taken (no higher event): ifid_flush=1, idex_flush=1.
- MEMWAIT:
  - Same freeze outputs as the RUN memory-wait case. branch_taken and load_use are ignored.
  - mem_ready=1: all enables 1 this cycle (the access retires into MEM/WB); next state RUN; wait_cnt<=0.
  - Else, if wait_cnt==MEM_TIMEOUT: next state EXC; exc_cause<=2.
  - Else: wait_cnt<=wait_cnt+1.
- EXC (exactly one cycle):
  - pc_sel_exc=1, pc_en=1, ifid_flush=1, idex_flush=1, exmem_flush=1, memwb_bubble=1.
  - Next state RUN. Inputs are ignored.
- stall_cnt increments on every negedge with pc_en=0 and rst_n=1. It saturates at all-ones and does not wrap.
- Reset asserted mid-MEMWAIT or mid-EXC: immediate return to RUN with all counters cleared. No pending exception survives reset.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - the state enum (RUN=0, MEMWAIT=1, EXC=2);
  - the cause constants (CAUSE_NONE, CAUSE_OVF, CAUSE_MEMTMO);
  - the register-number width constant 5.
- Sub-module hazard_detect: the combinational load_use comparator. It is instanced once and can be reused later by the forwarding unit.

Test Plan:
- Load-use: ex_memread=1, ex_regwr=1, ex_rw=8, id_rs=8 -> exactly one cycle of pc_en=0, ifid_en=0, idex_flush=1; stall_cnt=1. Repeat with ex_rw=0 -> no stall.
- Taken branch: branch_taken=1 in RUN -> ifid_flush=1, idex_flush=1, pc_en=1 for one cycle. Branch during MEMWAIT -> no flush.
- Memory wait: mem_access=1, mem_ready low for 3 cycles, then high -> 3 frozen cycles with memwb_bubble=1, release on the 4th; stall_cnt=3; state returns to RUN.
- Timeout: mem_ready held 0 -> EXC after MEM_TIMEOUT+1 frozen cycles; pc_sel_exc pulses 1 cycle; exc_cause=2.
- Overflow coincident with load_use and branch_taken -> overflow wins: exmem_flush=1, memwb_bubble=1, next cycle pc_sel_exc=1, exc_cause=1.
- Async reset asserted mid-MEMWAIT between clock edges -> outputs take reset values immediately; after release, state=RUN and stall_cnt=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    localparam int unsigned REG_W = 5;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        EXC     = 2'd2
    } state_t;

    localparam logic [1:0] CAUSE_NONE   = 2'd0;
    localparam logic [1:0] CAUSE_OVF    = 2'd1;
    localparam logic [1:0] CAUSE_MEMTMO = 2'd2;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: a load in EX whose destination is read by the ID instruction.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic             ex_regwr,
    input  logic [REG_W-1:0] ex_rw,
    output logic             load_use
);

    // Register 0 is hardwired, so a load targeting it never creates a hazard.
    always_comb begin
        load_use = ex_memread & ex_regwr & (ex_rw != '0) &
                   ((ex_rw == id_rs) | (id_uses_rt & (ex_rw == id_rt)));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline; state advances on negedge clk.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned TMO_W       = 4,
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned STAT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic              id_uses_rt,
    input  logic              ex_memread,
    input  logic [4:0]        ex_rw,
    input  logic              ex_regwr,
    input  logic              branch_taken,
    input  logic              mem_access,
    input  logic              mem_ready,
    input  logic              overflow_mem,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              exmem_en,
    output logic              exmem_flush,
    output logic              memwb_bubble,
    output logic              pc_sel_exc,
    output logic [1:0]        exc_cause,
    output logic [STAT_W-1:0] stall_cnt
);

    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(MEM_TIMEOUT);

    state_t           state, state_nxt;
    logic [TMO_W-1:0] wait_cnt, wait_nxt;
    logic [1:0]       cause_nxt;
    logic             load_use;

    hazard_detect u_hazard_detect (
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rt (id_uses_rt),
        .ex_memread (ex_memread),
        .ex_regwr   (ex_regwr),
        .ex_rw      (ex_rw),
        .load_use   (load_use)
    );

    // Output decode and next-state: exception > memory wait > load-use > branch.
    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_en     = 1'b1;
        exmem_flush  = 1'b0;
        memwb_bubble = 1'b0;
        pc_sel_exc   = 1'b0;
        state_nxt    = state;
        wait_nxt     = wait_cnt;
        cause_nxt    = exc_cause;

        if (!rst_n) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            exmem_en     = 1'b0;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            exmem_flush  = 1'b1;
            memwb_bubble = 1'b1;
            state_nxt    = RUN;
            wait_nxt     = '0;
        end else begin
            case (state)
                RUN: begin
                    if (overflow_mem) begin
                        pc_en        = 1'b0;
                        ifid_flush   = 1'b1;
                        idex_flush   = 1'b1;
                        exmem_flush  = 1'b1;
                        memwb_bubble = 1'b1;
                        state_nxt    = EXC;
                        cause_nxt    = CAUSE_OVF;
                    end else if (mem_access && !mem_ready) begin
                        pc_en        = 1'b0;
                        ifid_en      = 1'b0;
                        exmem_en     = 1'b0;
                        memwb_bubble = 1'b1;
                        state_nxt    = MEMWAIT;
                        wait_nxt     = TMO_W'(1);
                    end else if (load_use) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                    end else if (branch_taken) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end
                end
                MEMWAIT: begin
                    if (mem_ready) begin
                        state_nxt = RUN;
                        wait_nxt  = '0;
                    end else begin
                        pc_en        = 1'b0;
                        ifid_en      = 1'b0;
                        exmem_en     = 1'b0;
                        memwb_bubble = 1'b1;
                        if (wait_cnt == TMO_LIMIT) begin
                            state_nxt = EXC;
                            cause_nxt = CAUSE_MEMTMO;
                            wait_nxt  = '0;
                        end else begin
                            wait_nxt = wait_cnt + 1'b1;
                        end
                    end
                end
                EXC: begin
                    pc_sel_exc   = 1'b1;
                    ifid_flush   = 1'b1;
                    idex_flush   = 1'b1;
                    exmem_flush  = 1'b1;
                    memwb_bubble = 1'b1;
                    state_nxt    = RUN;
                    wait_nxt     = '0;
                end
                default: begin
                    state_nxt = RUN;
                    wait_nxt  = '0;
                end
            endcase
        end
    end

    // State, wait counter, sticky cause and saturating stall statistics.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            wait_cnt  <= '0;
            exc_cause <= CAUSE_NONE;
            stall_cnt <= '0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_nxt;
            exc_cause <= cause_nxt;
            if (!pc_en && !(&stall_cnt)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; inputs change just after negedge, checks mid-cycle.
module tb_pipe_hazard_ctrl;
    import pipe_ctrl_pkg::*;

    logic        clk = 1'b1;
    logic        rst_n;
    logic [4:0]  id_rs, id_rt, ex_rw;
    logic        id_uses_rt, ex_memread, ex_regwr, branch_taken;
    logic        mem_access, mem_ready, overflow_mem;
    logic        pc_en, ifid_en, ifid_flush, idex_flush;
    logic        exmem_en, exmem_flush, memwb_bubble, pc_sel_exc;
    logic [1:0]  exc_cause;
    logic [15:0] stall_cnt;

    logic        s_pc_en, s_ifid_en, s_ifid_flush, s_idex_flush;
    logic        s_exmem_en, s_exmem_flush, s_memwb_bubble, s_pc_sel_exc;
    logic [1:0]  s_exc_cause;
    logic [2:0]  s_stall_cnt;

    int errors = 0;
    int checks = 0;

    localparam logic [7:0] C_RUN   = 8'b1100_1000;
    localparam logic [7:0] C_LU    = 8'b0001_1000;
    localparam logic [7:0] C_BR    = 8'b1111_1000;
    localparam logic [7:0] C_FRZ   = 8'b0000_0010;
    localparam logic [7:0] C_OVF   = 8'b0111_1110;
    localparam logic [7:0] C_EXC   = 8'b1111_1111;
    localparam logic [7:0] C_RESET = 8'b0011_0110;

    wire [7:0] ctrl = {pc_en, ifid_en, ifid_flush, idex_flush,
                       exmem_en, exmem_flush, memwb_bubble, pc_sel_exc};

    pipe_hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_memread(ex_memread), .ex_rw(ex_rw),
        .ex_regwr(ex_regwr), .branch_taken(branch_taken), .mem_access(mem_access),
        .mem_ready(mem_ready), .overflow_mem(overflow_mem), .pc_en(pc_en),
        .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_en(exmem_en), .exmem_flush(exmem_flush), .memwb_bubble(memwb_bubble),
        .pc_sel_exc(pc_sel_exc), .exc_cause(exc_cause), .stall_cnt(stall_cnt)
    );

    // Narrow statistics counter to reach saturation quickly.
    pipe_hazard_ctrl #(.STAT_W(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_memread(ex_memread), .ex_rw(ex_rw),
        .ex_regwr(ex_regwr), .branch_taken(branch_taken), .mem_access(mem_access),
        .mem_ready(mem_ready), .overflow_mem(overflow_mem), .pc_en(s_pc_en),
        .ifid_en(s_ifid_en), .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush),
        .exmem_en(s_exmem_en), .exmem_flush(s_exmem_flush), .memwb_bubble(s_memwb_bubble),
        .pc_sel_exc(s_pc_sel_exc), .exc_cause(s_exc_cause), .stall_cnt(s_stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = '0; id_rt = '0; ex_rw = '0;
        id_uses_rt = 0; ex_memread = 0; ex_regwr = 0; branch_taken = 0;
        mem_access = 0; mem_ready = 0; overflow_mem = 0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        #3;
        check("reset_ctrl", 32'(ctrl), 32'(C_RESET));
        check("reset_stall", 32'(stall_cnt), 32'd0);
        check("reset_cause", 32'(exc_cause), 32'(CAUSE_NONE));
        #9 rst_n = 1'b1;
        #1 check("run_idle", 32'(ctrl), 32'(C_RUN));
        tick();
        check("idle_stall", 32'(stall_cnt), 32'd0);

        // Load-use through rs
        ex_memread = 1; ex_regwr = 1; ex_rw = 5'd8; id_rs = 5'd8;
        #2 check("lu_rs_ctrl", 32'(ctrl), 32'(C_LU));
        tick();
        check("lu_rs_stall", 32'(stall_cnt), 32'd1);
        check("lu_rs_state", 32'(dut.state), 32'(RUN));
        clear_inputs();
        #2 check("lu_after", 32'(ctrl), 32'(C_RUN));
        tick();
        check("lu_once", 32'(stall_cnt), 32'd1);

        // Load-use through rt, then rt not used
        ex_memread = 1; ex_regwr = 1; ex_rw = 5'd9; id_rs = 5'd3; id_rt = 5'd9; id_uses_rt = 1;
        #2 check("lu_rt_ctrl", 32'(ctrl), 32'(C_LU));
        id_uses_rt = 0;
        #1 check("lu_rt_unused", 32'(ctrl), 32'(C_RUN));
        id_uses_rt = 1;
        tick();
        check("lu_rt_stall", 32'(stall_cnt), 32'd2);

        // Destination r0 never stalls
        ex_rw = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
        #2 check("lu_r0", 32'(ctrl), 32'(C_RUN));
        tick();
        check("lu_r0_stall", 32'(stall_cnt), 32'd2);
        clear_inputs();

        // Taken branch in RUN
        branch_taken = 1;
        #2 check("branch_ctrl", 32'(ctrl), 32'(C_BR));
        tick();
        check("branch_stall", 32'(stall_cnt), 32'd2);
        clear_inputs();

        // Memory wait: 3 frozen cycles, branch ignored while waiting
        mem_access = 1;
        #2 check("mw1_ctrl", 32'(ctrl), 32'(C_FRZ));
        tick();
        check("mw1_state", 32'(dut.state), 32'(MEMWAIT));
        branch_taken = 1;
        #2 check("mw2_branch_ignored", 32'(ctrl), 32'(C_FRZ));
        tick();
        branch_taken = 0;
        #2 check("mw3_ctrl", 32'(ctrl), 32'(C_FRZ));
        tick();
        mem_ready = 1;
        #2 check("mw_release", 32'(ctrl), 32'(C_RUN));
        tick();
        check("mw_state_run", 32'(dut.state), 32'(RUN));
        check("mw_stall", 32'(stall_cnt), 32'd5);
        clear_inputs();

        // Timeout: 16 frozen cycles then a one-cycle exception with inputs ignored
        mem_access = 1;
        for (int i = 0; i < 16; i++) begin
            #2 check($sformatf("tmo_frz%0d", i), 32'(ctrl), 32'(C_FRZ));
            tick();
        end
        overflow_mem = 1;
        #2 check("tmo_exc_ctrl", 32'(ctrl), 32'(C_EXC));
        check("tmo_cause", 32'(exc_cause), 32'(CAUSE_MEMTMO));
        tick();
        check("tmo_state_run", 32'(dut.state), 32'(RUN));
        check("tmo_stall", 32'(stall_cnt), 32'd21);
        check("tmo_cause_held", 32'(exc_cause), 32'(CAUSE_MEMTMO));
        clear_inputs();

        // Overflow coincident with load-use and branch
        overflow_mem = 1; branch_taken = 1;
        ex_memread = 1; ex_regwr = 1; ex_rw = 5'd4; id_rs = 5'd4;
        #2 check("ovf_ctrl", 32'(ctrl), 32'(C_OVF));
        tick();
        clear_inputs();
        check("ovf_cause", 32'(exc_cause), 32'(CAUSE_OVF));
        check("ovf_stall", 32'(stall_cnt), 32'd22);
        #2 check("ovf_exc_ctrl", 32'(ctrl), 32'(C_EXC));
        tick();
        check("ovf_back_run", 32'(ctrl), 32'(C_RUN));
        check("sat_stall", 32'(s_stall_cnt), 32'd7);

        // Async reset asserted between edges while in MEMWAIT
        mem_access = 1;
        tick();
        tick();
        check("pre_rst_state", 32'(dut.state), 32'(MEMWAIT));
        #2 rst_n = 1'b0;
        clear_inputs();
        #1 check("arst_ctrl", 32'(ctrl), 32'(C_RESET));
        check("arst_stall", 32'(stall_cnt), 32'd0);
        check("arst_cause", 32'(exc_cause), 32'(CAUSE_NONE));
        check("arst_state", 32'(dut.state), 32'(RUN));
        #2 rst_n = 1'b1;
        #1 check("post_rst_ctrl", 32'(ctrl), 32'(C_RUN));
        tick();
        check("post_rst_stall", 32'(stall_cnt), 32'd0);
        check("post_rst_wait", 32'(dut.wait_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
